// File: rtl/updown_decoder_3bit.sv
// rtl/updown_decoder_3bit.sv - direction/lock tracker for a sampled 3-bit up/down counter
module updown_decoder_3bit #(
  parameter int LOCK_STEPS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic [2:0] q_in,
  output logic       dir,
  output logic       locked,
  output logic       hold,
  output logic       wrap,
  output logic       step_err,
  output logic [3:0] run_len,
  output logic [3:0] err_cnt
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_STEPS);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, ERR} state_t;

  state_t     state;
  logic [2:0] prev;
  logic [2:0] delta;
  logic       is_up, is_down, is_hold;
  logic [3:0] run_inc, err_inc;

  always_comb begin
    delta   = q_in - prev;
    is_up   = (delta == 3'd1);
    is_down = (delta == 3'd7);
    is_hold = (delta == 3'd0);
    run_inc = (run_len == 4'd15) ? 4'd15 : run_len + 4'd1;
    err_inc = (err_cnt == 4'd15) ? 4'd15 : err_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prev     <= 3'd0;
      dir      <= 1'b0;
      locked   <= 1'b0;
      hold     <= 1'b0;
      wrap     <= 1'b0;
      step_err <= 1'b0;
      run_len  <= 4'd0;
      err_cnt  <= 4'd0;
    end else begin
      hold     <= 1'b0;
      wrap     <= 1'b0;
      step_err <= 1'b0;
      if (sample_en) begin
        prev <= q_in;
        case (state)
          IDLE: begin
            run_len <= 4'd0;
            state   <= ACQ;
          end
          ERR: state <= ACQ;
          ACQ, LOCKED: begin
            if (is_hold) begin
              hold <= 1'b1;
            end else if (is_up || is_down) begin
              wrap <= (is_up && prev == 3'd7) || (is_down && prev == 3'd0);
              dir  <= is_up;
              if (state == ACQ) begin
                // A reversal during acquisition restarts the run in the new direction.
                if (run_len == 4'd0 || is_up == dir) begin
                  run_len <= run_inc;
                  if (run_inc >= LOCK_N) begin
                    state  <= LOCKED;
                    locked <= 1'b1;
                  end
                end else begin
                  run_len <= 4'd1;
                  if (LOCK_N == 4'd1) begin
                    state  <= LOCKED;
                    locked <= 1'b1;
                  end
                end
              end else begin
                run_len <= (is_up == dir) ? run_inc : 4'd1;
              end
            end else begin
              step_err <= 1'b1;
              err_cnt  <= err_inc;
              locked   <= 1'b0;
              run_len  <= 4'd0;
              state    <= ERR;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updown_decoder_3bit.sv
// tb/tb_updown_decoder_3bit.sv - scoreboard bench for updown_decoder_3bit
module tb_updown_decoder_3bit;

  localparam int LOCK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_en = 1'b0;
  logic [2:0] q_in = 3'd0;
  logic       dir, locked, hold, wrap, step_err;
  logic [3:0] run_len, err_cnt;

  updown_decoder_3bit #(.LOCK_STEPS(LOCK)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .q_in(q_in),
    .dir(dir), .locked(locked), .hold(hold), .wrap(wrap),
    .step_err(step_err), .run_len(run_len), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dir, locked, hold, wrap, step_err;
    logic [3:0] run_len, err_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // reference model state: 0 idle, 1 acq, 2 locked, 3 err
  int         ms = 0;
  logic [2:0] mp = 3'd0;
  logic       md = 1'b0;
  logic       ml = 1'b0;
  int         mr = 0;
  int         me = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    ms = 0; mp = 3'd0; md = 1'b0; ml = 1'b0; mr = 0; me = 0;
  endtask

  task automatic model_step(input logic en, input logic [2:0] v);
    exp_t       e;
    logic [2:0] d;
    logic       up;
    logic       mh, mw, mse;
    mh = 1'b0; mw = 1'b0; mse = 1'b0;
    if (en) begin
      d = v - mp;
      if (ms == 0 || ms == 3) begin
        if (ms == 0) mr = 0;
        ms = 1;
      end else if (d == 3'd0) begin
        mh = 1'b1;
      end else if (d == 3'd1 || d == 3'd7) begin
        up = (d == 3'd1);
        mw = (up && v == 3'd0) || (!up && v == 3'd7);
        if (mr == 0 || up == md) mr = (mr < 15) ? mr + 1 : 15;
        else mr = 1;
        md = up;
        if (ms == 1 && mr >= LOCK) begin ms = 2; ml = 1'b1; end
      end else begin
        mse = 1'b1;
        if (me < 15) me++;
        ml = 1'b0; mr = 0; ms = 3;
      end
      mp = v;
    end
    e.dir = md; e.locked = ml; e.hold = mh; e.wrap = mw; e.step_err = mse;
    e.run_len = 4'(mr); e.err_cnt = 4'(me);
    exp_q.push_back(e);
  endtask

  task automatic do_sample(input logic en, input logic [2:0] v);
    exp_t e;
    @(negedge clk);
    sample_en = en;
    q_in = v;
    model_step(en, v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("dir", dir, e.dir);
    check("locked", locked, e.locked);
    check("hold", hold, e.hold);
    check("wrap", wrap, e.wrap);
    check("step_err", step_err, e.step_err);
    check("run_len", run_len, e.run_len);
    check("err_cnt", err_cnt, e.err_cnt);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    sample_en = 1'b0;
    #1;
    check("rst_dir", dir, 0);
    check("rst_locked", locked, 0);
    check("rst_pulses", {hold, wrap, step_err}, 0);
    check("rst_run_len", run_len, 0);
    check("rst_err_cnt", err_cnt, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] cur;
    int         r;
    #1;
    check("init_rst_outputs", {dir, locked, hold, wrap, step_err, run_len, err_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;

    do_sample(1, 3); do_sample(1, 4); do_sample(1, 5);
    check("up_run_dir", dir, 1);
    check("up_run_len", run_len, 2);
    check("up_run_locked", locked, 1);

    mid_reset();
    do_sample(1, 6); do_sample(1, 7); do_sample(1, 0);
    check("wrap_at_0", wrap, 1);
    do_sample(1, 1);
    check("wrap_cleared", wrap, 0);
    check("wrap_run_len", run_len, 3);
    check("wrap_locked", locked, 1);

    mid_reset();
    do_sample(1, 2); do_sample(1, 3); do_sample(1, 4); do_sample(1, 3);
    check("rev_dir", dir, 0);
    check("rev_run_len", run_len, 1);
    check("rev_locked", locked, 1);
    do_sample(1, 2);
    check("rev_run_len2", run_len, 2);

    mid_reset();
    do_sample(1, 1); do_sample(1, 2); do_sample(1, 3); do_sample(1, 6);
    check("ill_step_err", step_err, 1);
    check("ill_err_cnt", err_cnt, 1);
    check("ill_locked", locked, 0);
    do_sample(1, 7);
    check("ill_reload_quiet", {hold, wrap, step_err}, 0);
    do_sample(1, 0);
    check("ill_run_len", run_len, 1);
    check("ill_acq_unlocked", locked, 0);

    mid_reset();
    do_sample(1, 5); do_sample(1, 6);
    for (int i = 0; i < 3; i++) do_sample(0, 3'(i));
    do_sample(1, 6);
    check("hold_pulse", hold, 1);
    check("hold_run_len", run_len, 1);

    mid_reset();
    do_sample(1, 0); do_sample(1, 5); do_sample(1, 5); do_sample(1, 6); do_sample(1, 7);
    check("pre_rst_locked", locked, 1);
    check("pre_rst_err_cnt", err_cnt, 1);
    mid_reset();
    do_sample(1, 4); do_sample(1, 5); do_sample(1, 6);
    check("relock_locked", locked, 1);
    check("relock_err_cnt", err_cnt, 0);

    mid_reset();
    for (int i = 0; i < 20; i++) do_sample(1, 3'(i));
    check("run_len_sat", run_len, 15);

    mid_reset();
    do_sample(1, 0);
    for (int i = 0; i < 40; i++) do_sample(1, ((i >> 1) & 1) ? 3'd0 : 3'd4);
    check("err_cnt_sat", err_cnt, 15);

    mid_reset();
    cur = 3'd0;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) cur = cur + 3'd1;
      else if (r < 7) cur = cur - 3'd1;
      else if (r == 9) cur = cur + 3'($urandom_range(2, 6));
      do_sample($urandom_range(0, 3) != 0, cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
